// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: execute-stage controller for the multi-cycle multiply path.
// Non-multiply ALU ops pass through in one cycle. A multiply (ALUCtrl_i == 3'b011)
// pulses mul_start_o, holds stall_o for MUL_LAT cycles and then strobes mul_done_o
// for one cycle so EX/MEM can capture the product.
// Optional feature macro: ALU_MUL_SEQ_PERF_CNT_EN adds the 32-bit perf_stall_o
// stall-cycle counter.
//
// Handshake: there is no ready/valid back-pressure here. valid_i qualifies
// ALUCtrl_i in IDLE only. stall_o freezes the front of the pipeline, so the
// inputs are ignored while BUSY. mul_done_o is a one-cycle strobe with no
// acknowledge. flush_i overrides everything in every state.
module alu_mul_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        mul_start_o,
  output logic        mul_done_o,
  output logic        busy_o
`ifdef ALU_MUL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The start cycle is one stall cycle and the last BUSY cycle (cnt == 0) is
  // another, so the counter covers the remaining MUL_LAT-2 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             busy_q;
  logic             is_mul;
  logic             start_req;

  // Decode the multiply request that may be accepted from IDLE this cycle.
  always_comb begin
    is_mul    = (ALUCtrl_i == 3'b011);
    start_req = (state == IDLE) && valid_i && is_mul;
  end

  // Stall and start react combinationally in IDLE. Flush and reset both mask them.
  always_comb begin
    mul_start_o = rst_i && !flush_i && start_req;
    stall_o     = rst_i && !flush_i && (start_req || (state == BUSY));
    mul_done_o  = done_q && !flush_i;
    busy_o      = busy_q;
  end

  // Sequencer FSM: IDLE -> BUSY (latency countdown) -> DONE -> IDLE, with
  // registered done and busy flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (flush_i) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (valid_i && is_mul) begin
            state  <= BUSY;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        BUSY: begin
          busy_q <= 1'b1;
          if (cnt == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            cnt    <= cnt - 1'b1;
            done_q <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_MUL_SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Count every stall cycle. The count wraps naturally and only reset clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_cnt <= '0;
    end else if (stall_o) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_stall_o = perf_cnt;
`endif

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: drives two instances (MUL_LAT = 4 and MUL_LAT = 2) with
// the same stimulus. Each instance is compared every cycle against a
// position-in-multiply reference model.
module tb_alu_mul_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] alu = 3'b000;
  logic       flush = 1'b0;

  always #5 clk = ~clk;

  logic        stall4, start4, done4, busy4;
  logic        stall2, start2, done2, busy2;
  logic [31:0] perf4_o, perf2_o;

  alu_mul_sequencer #(.MUL_LAT(4), .CNT_W(3)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUCtrl_i(alu), .flush_i(flush),
    .stall_o(stall4), .mul_start_o(start4), .mul_done_o(done4), .busy_o(busy4)
`ifdef ALU_MUL_SEQ_PERF_CNT_EN
    , .perf_stall_o(perf4_o)
`endif
  );

  alu_mul_sequencer #(.MUL_LAT(2), .CNT_W(3)) dut2 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUCtrl_i(alu), .flush_i(flush),
    .stall_o(stall2), .mul_start_o(start2), .mul_done_o(done2), .busy_o(busy2)
`ifdef ALU_MUL_SEQ_PERF_CNT_EN
    , .perf_stall_o(perf2_o)
`endif
  );

`ifndef ALU_MUL_SEQ_PERF_CNT_EN
  assign perf4_o = 32'd0;
  assign perf2_o = 32'd0;
`endif

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pos = -1 means idle, otherwise pos is the cycle index
  // within the multiply (0 = start cycle, lat = done cycle).
  int          pos4 = -1;
  int          pos2 = -1;
  logic [31:0] perf4 = 32'd0;
  logic [31:0] perf2 = 32'd0;

  task automatic model_cycle(input int lat, inout int pos,
                             output logic e_start, output logic e_stall,
                             output logic e_done, output logic e_busy);
    e_start = 1'b0; e_stall = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    if (!rst_n) begin
      pos = -1;
    end else if (flush) begin
      e_busy = (pos >= 1);
      pos = -1;
    end else if (pos < 0) begin
      if (valid && alu == 3'b011) begin
        e_start = 1'b1;
        e_stall = 1'b1;
        pos = 1;
      end
    end else begin
      e_busy  = 1'b1;
      e_stall = (pos < lat);
      e_done  = (pos == lat);
      pos = (pos == lat) ? -1 : pos + 1;
    end
  endtask

  task automatic check_dut(input string name, input int lat, inout int pos,
                           inout logic [31:0] perf,
                           input logic o_start, input logic o_stall,
                           input logic o_done, input logic o_busy,
                           input logic [31:0] o_perf);
    logic e_start, e_stall, e_done, e_busy;
    model_cycle(lat, pos, e_start, e_stall, e_done, e_busy);
    if (!rst_n) perf = 32'd0;
    check({name, "_start"}, 32'(o_start), 32'(e_start));
    check({name, "_stall"}, 32'(o_stall), 32'(e_stall));
    check({name, "_done"},  32'(o_done),  32'(e_done));
    check({name, "_busy"},  32'(o_busy),  32'(e_busy));
`ifdef ALU_MUL_SEQ_PERF_CNT_EN
    check({name, "_perf"}, o_perf, perf);
`else
    if (o_perf != 32'd0) check({name, "_perf_tie"}, o_perf, 32'd0);
`endif
    if (e_stall) perf = perf + 32'd1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic v, input logic [2:0] a, input logic f);
    @(negedge clk);
    rst_n = r; valid = v; alu = a; flush = f;
    #1;
    check_dut("lat4", 4, pos4, perf4, start4, stall4, done4, busy4, perf4_o);
    check_dut("lat2", 2, pos2, perf2, start2, stall2, done2, busy2, perf2_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  logic [2:0] codes [4];

  initial begin
    codes[0] = 3'b010; codes[1] = 3'b110; codes[2] = 3'b000; codes[3] = 3'b001;

    // Reset held with a multiply presented: every output must stay 0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b011, 1'b0);
    // Release: multiply starts in the first cycle out of reset.
    step(1'b1, 1'b1, 3'b011, 1'b0);
    check("rst_release_start", 32'(start4), 32'd1);
    check("rst_release_stall", 32'(stall4), 32'd1);
    idle(6);

    // Single-cycle ops never stall.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, codes[i], 1'b0);

    // Multiply, flush in the second BUSY cycle, then a full restart.
    step(1'b1, 1'b1, 3'b011, 1'b0);
    step(1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b0, 3'b000, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 3'b011, 1'b0);
    idle(6);

    // Back-to-back multiplies: valid multiply held continuously.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 3'b011, 1'b0);
    idle(6);

    // Three multiplies after a fresh reset, for the stall counter.
    step(1'b0, 1'b0, 3'b000, 1'b0);
    for (int m = 0; m < 3; m++) begin
      step(1'b1, 1'b1, 3'b011, 1'b0);
      idle(5);
    end
`ifdef ALU_MUL_SEQ_PERF_CNT_EN
    check("perf4_three_mul", perf4_o, 32'd12);
    check("perf2_three_mul", perf2_o, 32'd6);
    // Preload the counter to all ones while idle, then one stall cycle wraps it.
    @(negedge clk);
    dut4.perf_cnt = 32'hFFFF_FFFF;
    perf4 = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, 3'b011, 1'b0);
    step(1'b1, 1'b0, 3'b000, 1'b0);
    idle(5);
`endif

    // Randomized traffic with occasional flushes and mid-operation resets.
    for (int i = 0; i < 3000; i++) begin
      logic       r, v, f;
      logic [2:0] a;
      r = ($urandom_range(0, 79) != 0);
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'($urandom_range(0, 7));
      f = ($urandom_range(0, 9) == 0);
      step(r, v, a, f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
